// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU command sequencer.
//   - default operand/result/register-file sizes
//   - ALU opcode encodings (ALU_ADD .. ALU_XOR)
//   - sequencer FSM state encoding
//   - result_is_wide(): flags results that do not fit the operand width
package alu_pkg;

    localparam int ALU_NREG = 4;
    localparam int ALU_DW   = 4;
    localparam int ALU_RW   = 8;
    localparam int ALU_AW   = $clog2(ALU_NREG);

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_MUL   = 3'd4;
    localparam logic [2:0] ALU_PASSA = 3'd5;
    localparam logic [2:0] ALU_PASSB = 3'd6;
    localparam logic [2:0] ALU_XOR   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    // True when any bit above the operand width is set, i.e. the register
    // file writeback (low nibble only) loses information.
    function automatic logic result_is_wide(input logic [ALU_RW-1:0] y);
        return (y[ALU_RW-1:ALU_DW] != {(ALU_RW-ALU_DW){1'b0}});
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW operand register file.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, clears every entry
//   we_i         write enable
//   waddr_i      write index
//   wdata_i      write data
//   raddr_a_i    read port A index    rdata_a_o  read port A data (async)
//   raddr_b_i    read port B index    rdata_b_o  read port B data (async)
module alu_regfile #(
    parameter int NREG = 4,
    parameter int DW   = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];

    // Register storage: clear on reset, otherwise single write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command sequencer in front of a combinational 4-bit ALU.
// Accepts load/ALU commands, reads operands from a small register file,
// drives the ALU for one cycle, captures the result, writes its low nibble
// back and holds the full result on a valid/ready output until consumed.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_load                   1 = load immediate, 0 = ALU operation
//   cmd_op, cmd_ra, cmd_rb,    opcode, source A/B and destination indices
//   cmd_rd, cmd_imm            and load immediate
//   alu_a, alu_b, alu_s        registered operands/select to the ALU
//   alu_y                      ALU result (combinational from alu_a/b/s)
//   res_valid/res_ready        result handshake
//   res_data, res_op, res_wide captured result, its opcode, overflow flag
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int NREG = ALU_NREG,
    parameter int DW   = ALU_DW,
    parameter int RW   = ALU_RW,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_load,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic [DW-1:0] cmd_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_s,
    input  logic [RW-1:0] alu_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [RW-1:0] res_data,
    output logic [2:0]    res_op,
    output logic          res_wide
);

    state_e        state_q;
    logic          cmd_ready_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] alu_a_q;
    logic [DW-1:0] alu_b_q;
    logic [2:0]    alu_s_q;
    logic          res_valid_q;
    logic [RW-1:0] res_data_q;
    logic [2:0]    res_op_q;
    logic          res_wide_q;

    logic          accept_s;
    logic [DW-1:0] rf_a_s;
    logic [DW-1:0] rf_b_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;

    // cmd_ready_q mirrors (state_q == IDLE) so the handshake uses a flop.
    assign accept_s = cmd_valid & cmd_ready_q;

    alu_regfile #(
        .NREG (NREG),
        .DW   (DW),
        .AW   (AW)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .we_i      (wr_en_s),
        .waddr_i   (wr_addr_s),
        .wdata_i   (wr_data_s),
        .raddr_a_i (cmd_ra),
        .rdata_a_o (rf_a_s),
        .raddr_b_i (cmd_rb),
        .rdata_b_o (rf_b_s)
    );

    // Write-port mux: ALU writeback in EXEC, otherwise an accepted load.
    // The two never collide because loads are only accepted in IDLE.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = cmd_rd;
        wr_data_s = cmd_imm;
        if (state_q == EXEC) begin
            wr_en_s   = 1'b1;
            wr_addr_s = rd_q;
            wr_data_s = alu_y[DW-1:0];
        end else if (accept_s && cmd_load) begin
            wr_en_s   = 1'b1;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered. Operands are sampled at
    // accept, so a destination equal to a source is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rd_q        <= {AW{1'b0}};
            alu_a_q     <= {DW{1'b0}};
            alu_b_q     <= {DW{1'b0}};
            alu_s_q     <= 3'd0;
            res_valid_q <= 1'b0;
            res_data_q  <= {RW{1'b0}};
            res_op_q    <= 3'd0;
            res_wide_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s && !cmd_load) begin
                        alu_a_q     <= rf_a_s;
                        alu_b_q     <= rf_b_s;
                        alu_s_q     <= cmd_op;
                        rd_q        <= cmd_rd;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    res_data_q  <= alu_y;
                    res_op_q    <= alu_s_q;
                    res_wide_q  <= result_is_wide(alu_y);
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s     = alu_s_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_wide  = res_wide_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq: behavioural ALU, directed stimulus, and a
// scoreboard queue consumed by a monitor thread on each result handshake.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_ra;
    logic [1:0] cmd_rb;
    logic [1:0] cmd_rd;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_s;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_op;
    logic       res_wide;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] op;
        logic       wide;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_cmd_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_op    (res_op),
        .res_wide  (res_wide)
    );

    // Behavioural 4-bit ALU feeding alu_y back to the sequencer.
    always_comb begin
        case (alu_s)
            3'd0:    alu_y = {4'h0, alu_a} + {4'h0, alu_b};
            3'd1:    alu_y = {4'h0, alu_a} - {4'h0, alu_b};
            3'd2:    alu_y = {4'h0, alu_a & alu_b};
            3'd3:    alu_y = {4'h0, alu_a | alu_b};
            3'd4:    alu_y = {4'h0, alu_a} * {4'h0, alu_b};
            3'd5:    alu_y = {4'h0, alu_a};
            3'd6:    alu_y = {4'h0, alu_b};
            default: alu_y = {4'h0, alu_a ^ alu_b};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] data, input logic [2:0] op);
        exp_t e;
        e.data = data;
        e.op   = op;
        e.wide = (data[7:4] != 4'h0);
        exp_q.push_back(e);
    endtask

    // Present a command, wait (bounded) for it to be accepted, then scramble
    // the fields to show they are only needed up to the accept edge.
    task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [1:0] rd, input logic [3:0] imm);
        int k;
        @(negedge clk);
        cmd_load  = ld;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) check("accept_timeout", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_ra    = ~ra;
        cmd_rb    = ~rb;
        cmd_rd    = ~rd;
        cmd_imm   = ~imm;
    endtask

    task automatic load(input logic [1:0] rd, input logic [3:0] imm);
        send(1'b1, 3'd0, 2'd0, 2'd0, rd, imm);
    endtask

    // Wait until every expected result has been consumed and the sequencer is idle.
    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || !cmd_ready) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("drain", {31'd0, (exp_q.size() == 0) && cmd_ready}, 32'd1);
    endtask

    task automatic rop(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                       input logic [1:0] rd, input logic [7:0] exp_data);
        push_exp(exp_data, op);
        send(1'b0, op, ra, rb, rd, 4'h0);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sweep_exp [8];
        logic       rdy_exp   [5];
        logic       rv_exp    [5];

        sweep_exp = '{8'h10, 8'h04, 8'h02, 8'h0E, 8'h3C, 8'h0A, 8'h06, 8'h0C};
        rdy_exp   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        rv_exp    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Monitor: pop and compare on every result handshake.
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                #1;
                if (!rst && res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_result: got data 0x%0h op %0d, expected none", res_data, res_op);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", {24'd0, res_data}, {24'd0, e.data});
                        check("res_op",   {29'd0, res_op},   {29'd0, e.op});
                        check("res_wide", {31'd0, res_wide}, {31'd0, e.wide});
                    end
                end
            end
        join_none

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'd0;
        cmd_ra    = 2'd0;
        cmd_rb    = 2'd0;
        cmd_rd    = 2'd0;
        cmd_imm   = 4'h0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data",  {24'd0, res_data},  32'd0);
        check("rst_res_op",    {29'd0, res_op},    32'd0);
        check("rst_res_wide",  {31'd0, res_wide},  32'd0);
        check("rst_alu_a",     {28'd0, alu_a},     32'd0);
        check("rst_alu_b",     {28'd0, alu_b},     32'd0);
        check("rst_alu_s",     {29'd0, alu_s},     32'd0);
        rst = 1'b0;

        // 1: subtract wraps, latency, writeback of low nibble.
        load(2'd0, 4'h3);
        load(2'd1, 4'h5);
        push_exp(8'hFE, ALU_SUB);
        send(1'b0, ALU_SUB, 2'd0, 2'd1, 2'd2, 4'h0);
        check("lat_exec_valid", {31'd0, res_valid}, 32'd0);
        check("lat_exec_ready", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        check("lat_hold_valid", {31'd0, res_valid}, 32'd1);
        drain();
        rop(ALU_PASSA, 2'd2, 2'd0, 2'd3, 8'h0E);

        // 2: full-width multiply, then reuse of its truncated writeback.
        load(2'd0, 4'hF);
        load(2'd1, 4'hF);
        rop(ALU_MUL, 2'd0, 2'd1, 2'd3, 8'hE1);
        rop(ALU_ADD, 2'd3, 2'd3, 2'd0, 8'h02);

        // 3: back-pressure in HOLD; a command presented meanwhile is ignored.
        load(2'd0, 4'h2);
        load(2'd1, 4'h3);
        res_ready = 1'b0;
        push_exp(8'h05, ALU_ADD);
        send(1'b0, ALU_ADD, 2'd0, 2'd1, 2'd2, 4'h0);
        for (int k = 0; k < 10 && !res_valid; k++) @(negedge clk);
        check("hold_reached", {31'd0, res_valid}, 32'd1);
        cmd_load  = 1'b1;
        cmd_rd    = 2'd0;
        cmd_imm   = 4'h9;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data",  {24'd0, res_data},  32'h05);
            check("hold_op",    {29'd0, res_op},    {29'd0, ALU_ADD});
            check("hold_ready", {31'd0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        drain();
        rop(ALU_PASSA, 2'd0, 2'd1, 2'd3, 8'h02);

        // 4: reset during EXEC discards the op and its writeback.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load(2'd0, 4'h3);
        load(2'd2, 4'h4);
        send(1'b0, ALU_ADD, 2'd0, 2'd2, 2'd1, 4'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("exec_rst_valid", {31'd0, res_valid}, 32'd0);
        check("exec_rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("exec_rst_data",  {24'd0, res_data},  32'd0);
        rop(ALU_PASSA, 2'd1, 2'd0, 2'd3, 8'h00);

        // 5: opcode sweep with A=0xA, B=0x6.
        load(2'd0, 4'hA);
        load(2'd1, 4'h6);
        for (int i = 0; i < 8; i++) begin
            rop(3'(i), 2'd0, 2'd1, 2'd3, sweep_exp[i]);
        end

        // 6: load, op, load with cmd_valid held high throughout.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                cmd_valid = 1'b1;
                cmd_load  = 1'b1;
                cmd_rd    = 2'd0;
                cmd_imm   = 4'h1;
            end else if (c == 1) begin
                cmd_load  = 1'b0;
                cmd_op    = ALU_ADD;
                cmd_ra    = 2'd0;
                cmd_rb    = 2'd0;
                cmd_rd    = 2'd1;
                push_exp(8'h02, ALU_ADD);
            end else if (c == 2) begin
                cmd_load  = 1'b1;
                cmd_rd    = 2'd2;
                cmd_imm   = 4'h5;
            end
            check($sformatf("b2b_ready_c%0d", c), {31'd0, cmd_ready}, {31'd0, rdy_exp[c]});
            check($sformatf("b2b_valid_c%0d", c), {31'd0, res_valid}, {31'd0, rv_exp[c]});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        drain();
        rop(ALU_PASSA, 2'd1, 2'd2, 2'd3, 8'h02);
        rop(ALU_PASSB, 2'd1, 2'd2, 2'd3, 8'h05);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
